// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: md_op encodings,
// default latencies and the 64-bit {hi,lo} result type.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef logic [63:0] md_result_t;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing {hi,lo} and a
// divide-by-zero indicator; the controller decides when to commit it.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output md_result_t  result,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Signed divide works on magnitudes so that 0x80000000 / -1 wraps
    // naturally to 0x80000000 with remainder 0 instead of overflowing.
    always_comb begin
        prod_s     = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u     = {32'd0, rs} * {32'd0, rt};
        signed_div = (md_op == MD_DIV);
        rs_mag     = (signed_div && rs[31]) ? (32'd0 - rs) : rs;
        rt_mag     = (signed_div && rt[31]) ? (32'd0 - rt) : rt;
        divisor    = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
        q_mag      = rs_mag / divisor;
        r_mag      = rs_mag % divisor;
        quot       = (signed_div && (rs[31] ^ rt[31])) ? (32'd0 - q_mag) : q_mag;
        rem        = (signed_div && rs[31]) ? (32'd0 - r_mag) : r_mag;
        div0       = md_is_div(md_op) && (rt == 32'd0);

        case (md_op)
            MD_MULT:         result = prod_s;
            MD_MULTU:        result = prod_u;
            MD_DIV, MD_DIVU: result = {rem, quot};
            default:         result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO owner beside the EX ALU: latches an md result at issue and commits it
// after a fixed countdown. Optional div0 pulse output: define MD_DIV0_FLAG_EN.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef MD_DIV0_FLAG_EN
    ,
    output logic        div0
`endif
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic       state;
    logic [3:0] count;
    md_result_t buffer;
    logic       div0_pend;
    md_result_t arith_result;
    logic       arith_div0;

    md_arith u_arith (
        .md_op  (md_op),
        .rs     (rs_val),
        .rt     (rt_val),
        .result (arith_result),
        .div0   (arith_div0)
    );

    assign busy = (state == ST_RUN);

    // The result is captured at issue, so operand changes while running are
    // irrelevant; a divide by zero still runs full length but never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= 4'd0;
            buffer    <= 64'd0;
            div0_pend <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
`ifdef MD_DIV0_FLAG_EN
            div0      <= 1'b0;
`endif
        end else begin
`ifdef MD_DIV0_FLAG_EN
            div0 <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (md_is_mult(md_op)) begin
                            buffer    <= arith_result;
                            div0_pend <= 1'b0;
                            count     <= MULT_CNT;
                            state     <= ST_RUN;
                        end else if (md_is_div(md_op)) begin
                            buffer    <= arith_result;
                            div0_pend <= arith_div0;
                            count     <= DIV_CNT;
                            state     <= ST_RUN;
                        end else if (md_op == MD_MTHI) begin
                            hi <= rs_val;
                        end else if (md_op == MD_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                default: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= ST_IDLE;
                        if (!div0_pend) begin
                            hi <= buffer[63:32];
                            lo <= buffer[31:0];
                        end
`ifdef MD_DIV0_FLAG_EN
                        div0 <= div0_pend;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed, table-driven bench for md_ctrl with hand-computed HI/LO results,
// plus hand sequences for back-to-back MT ops, ignored issues and reset abort.
module tb_md_ctrl;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

`ifdef MD_DIV0_FLAG_EN
    logic div0;
    int   div0_pulses = 0;
    always @(negedge clk) if (div0) div0_pulses++;
`endif

    md_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
`ifdef MD_DIV0_FLAG_EN
        ,
        .div0   (div0)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        md_op  = op;
        rs_val = rs;
        rt_val = rt;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rs_val = 32'hA5A5A5A5;
        rt_val = 32'h5A5A5A5A;
    endtask

    task automatic checkOutput(input string name, input logic exp_busy,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        checks++;
        if (busy !== exp_busy || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("[TB] FAIL %s: got busy=%0b hi=%08h lo=%08h, want busy=%0b hi=%08h lo=%08h",
                     name, busy, hi, lo, exp_busy, exp_hi, exp_lo);
        end
    endtask

    task automatic checkCycles(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s busy cycles: got %0d, want %0d", name, got, want);
        end
    endtask

    // Counts busy cycles starting right after the issue edge, bounded.
    task automatic countBusy(inout int n);
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;

        vecs[0]  = '{"mult_neg3x7",   OP_MULT,  32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{"multu_max_x2",  OP_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{"div_neg7_2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"mthi_11",       OP_MTHI,  32'h00000011, 32'd0,        0,  32'h00000011, 32'hFFFFFFFD};
        vecs[4]  = '{"mtlo_22",       OP_MTLO,  32'h00000022, 32'd0,        0,  32'h00000011, 32'h00000022};
        vecs[5]  = '{"divu_by_zero",  OP_DIVU,  32'd7,        32'd0,        10, 32'h00000011, 32'h00000022};
        vecs[6]  = '{"div_overflow",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[7]  = '{"divu_max_10",   OP_DIVU,  32'hFFFFFFFF, 32'd10,       10, 32'h00000005, 32'h19999999};
        vecs[8]  = '{"div_7_neg2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{"mult_min_sq",   OP_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
        vecs[10] = '{"none_op",       OP_NONE,  32'h12345678, 32'h9ABCDEF0, 0,  32'h40000000, 32'h00000000};
        vecs[11] = '{"reserved_op",   OP_RSVD,  32'h12345678, 32'h9ABCDEF0, 0,  32'h40000000, 32'h00000000};
        vecs[12] = '{"multu_2p16sq",  OP_MULTU, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 1'b0, 32'd0, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt);
            n = 0;
            countBusy(n);
            checkCycles(vecs[i].name, n, vecs[i].cycles);
            checkOutput(vecs[i].name, 1'b0, vecs[i].hi, vecs[i].lo);
            @(posedge clk);
            #1;
        end

`ifdef MD_DIV0_FLAG_EN
        checks++;
        if (div0_pulses != 1) begin
            errors++;
            $display("[TB] FAIL div0_pulse_count: got %0d, want 1", div0_pulses);
        end
`endif

        // Back-to-back MTHI then MTLO, one edge apart.
        md_op  = OP_MTHI;
        rs_val = 32'hDEADBEEF;
        start  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mthi_b2b", 1'b0, 32'hDEADBEEF, 32'h00000000);
        md_op  = OP_MTLO;
        rs_val = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("mtlo_b2b", 1'b0, 32'hDEADBEEF, 32'h12345678);

        // Issues while busy are ignored and operands are captured at issue.
        applyStimulus(OP_MULT, 32'd5, 32'd5);
        n = 1;
        @(posedge clk);
        #1;
        n++;
        md_op  = OP_MTLO;
        rs_val = 32'h00000099;
        start  = 1'b1;
        @(posedge clk);
        #1;
        n++;
        checkOutput("ignored_mtlo", 1'b1, 32'hDEADBEEF, 32'h12345678);
        md_op  = OP_DIV;
        rs_val = 32'd100;
        rt_val = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy === 1'b1) begin
            n++;
            @(posedge clk);
            #1;
        end
        countBusy(n);
        checkCycles("ignored_issue", n, 5);
        checkOutput("ignored_issue", 1'b0, 32'd0, 32'd25);
        @(posedge clk);
        #1;
        checkOutput("no_late_div", 1'b0, 32'd0, 32'd25);

        // Reset in the 4th busy cycle aborts the pending DIV.
        applyStimulus(OP_DIV, 32'd100, 32'd3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("div_running", 1'b1, 32'd0, 32'd25);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_abort", 1'b0, 32'd0, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("no_write_after_reset", 1'b0, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
